// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline bundle: decoded fields from ID (id_*) and registered fields to EX (ex_*).
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              id_valid;
  logic              id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic              id_branch, id_alu_src, id_reg_dst;
  logic [1:0]        id_alu_op;
  logic              id_uses_rs, id_uses_rt;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic [4:0]        id_shamt;

  logic              ex_valid;
  logic              ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic              ex_branch, ex_alu_src, ex_reg_dst;
  logic [1:0]        ex_alu_op;
  logic [5:0]        ex_funct;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic [4:0]        ex_shamt;

  // ID side: drives decoded fields, observes EX contents
  modport master (
    output id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_branch, id_alu_src, id_reg_dst, id_alu_op, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, id_shamt,
    input  ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_funct,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd, ex_shamt
  );

  // Stage register side: samples ID fields, drives EX fields
  modport slave (
    input  id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_branch, id_alu_src, id_reg_dst, id_alu_op, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, id_shamt,
    output ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_funct,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd, ex_shamt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use detection, bubble insertion, hold and flush.
// Update priority per edge: reset > flush (bubble) > hold (freeze) > load-use (bubble) > load.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  hazard_stall,
  id_ex_stage_reg_if.slave      bus
);

  logic              r_valid;
  logic              r_reg_write, r_mem_to_reg, r_mem_read, r_mem_write;
  logic              r_branch, r_alu_src, r_reg_dst;
  logic [1:0]        r_alu_op;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm, r_pc4;
  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic [4:0]        r_shamt;

  logic w_hazard;
  logic w_load;
  logic w_bubble;

  // Load-use: a load in EX whose destination (rt, never r0) is read by the ID instruction
  always_comb begin
    w_hazard = r_valid & r_mem_read & bus.id_valid & (r_rt != '0) &
               ((bus.id_uses_rs & (bus.id_rs == r_rt)) |
                (bus.id_uses_rt & (bus.id_rt == r_rt)));
    // flush overrides hold; otherwise hold freezes everything
    w_load   = flush | ~hold;
    // a bubble also covers an empty ID slot so stale control never reaches EX
    w_bubble = flush | w_hazard | ~bus.id_valid;
  end

  // Pipeline register update; data fields always follow ID on a load, bubbles only clear control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_dst   <= 1'b0;
      r_alu_op    <= 2'b00;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_pc4       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_shamt     <= '0;
    end else if (w_load) begin
      r_rs_data <= bus.id_rs_data;
      r_rt_data <= bus.id_rt_data;
      r_imm     <= bus.id_imm;
      r_pc4     <= bus.id_pc4;
      r_rs      <= bus.id_rs;
      r_rt      <= bus.id_rt;
      r_rd      <= bus.id_rd;
      r_shamt   <= bus.id_shamt;
      if (w_bubble) begin
        r_valid      <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_branch     <= 1'b0;
        r_alu_src    <= 1'b0;
        r_reg_dst    <= 1'b0;
        r_alu_op     <= 2'b00;
      end else begin
        r_valid      <= 1'b1;
        r_reg_write  <= bus.id_reg_write;
        r_mem_to_reg <= bus.id_mem_to_reg;
        r_mem_read   <= bus.id_mem_read;
        r_mem_write  <= bus.id_mem_write;
        r_branch     <= bus.id_branch;
        r_alu_src    <= bus.id_alu_src;
        r_reg_dst    <= bus.id_reg_dst;
        r_alu_op     <= bus.id_alu_op;
      end
    end
  end

  // Present registered state to EX; Funct is the low bits of the registered immediate
  always_comb begin
    hazard_stall      = w_hazard;
    bus.ex_valid      = r_valid;
    bus.ex_reg_write  = r_reg_write;
    bus.ex_mem_to_reg = r_mem_to_reg;
    bus.ex_mem_read   = r_mem_read;
    bus.ex_mem_write  = r_mem_write;
    bus.ex_branch     = r_branch;
    bus.ex_alu_src    = r_alu_src;
    bus.ex_reg_dst    = r_reg_dst;
    bus.ex_alu_op     = r_alu_op;
    bus.ex_funct      = r_imm[5:0];
    bus.ex_rs_data    = r_rs_data;
    bus.ex_rt_data    = r_rt_data;
    bus.ex_imm        = r_imm;
    bus.ex_pc4        = r_pc4;
    bus.ex_rs         = r_rs;
    bus.ex_rt         = r_rt;
    bus.ex_rd         = r_rd;
    bus.ex_shamt      = r_shamt;
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for the ID/EX stage register: vector table plus hand sequences.
module tb_id_ex_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic hold;
  logic flush;
  logic hazard_stall;

  int n_cmp = 0;
  int n_bad = 0;

  // control bundle order: {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst}
  localparam logic [6:0] C_LW  = 7'b1110010;
  localparam logic [6:0] C_ADD = 7'b1000001;
  localparam logic [6:0] C_SW  = 7'b0001010;
  localparam logic [6:0] C_NONE = 7'b0000000;

  id_ex_stage_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

  id_ex_stage_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [6:0] ctrl;
    logic [1:0] op;
    logic       urs;
    logic       urt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [31:0] imm;
    logic       hold;
    logic       flush;
    logic       e_hz;
    logic       e_valid;
    logic [6:0] e_ctrl;
    logic [1:0] e_op;
    logic       chk;
    logic [4:0] e_rs;
    logic [4:0] e_rt;
    logic [5:0] e_funct;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ex_ctrl();
    return {bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read, bus.ex_mem_write,
            bus.ex_branch, bus.ex_alu_src, bus.ex_reg_dst};
  endfunction

  task automatic drive(input logic v, input logic [6:0] c, input logic [1:0] op,
                       input logic urs, input logic urt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
    bus.id_valid      = v;
    {bus.id_reg_write, bus.id_mem_to_reg, bus.id_mem_read, bus.id_mem_write,
     bus.id_branch, bus.id_alu_src, bus.id_reg_dst} = c;
    bus.id_alu_op     = op;
    bus.id_uses_rs    = urs;
    bus.id_uses_rt    = urt;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rd         = rd;
    bus.id_shamt      = rd;
    bus.id_imm        = imm;
    bus.id_rs_data    = 32'h1000 + 32'(rs);
    bus.id_rt_data    = 32'h2000 + 32'(rt);
    bus.id_pc4        = 32'h400 + imm;
  endtask

  initial begin
    // valid ctrl op urs urt rs rt rd imm hold flush | hz valid ctrl op chk rs rt funct
    vt[0]  = '{1'b1, C_LW,  2'b00, 1'b1, 1'b0, 5'd1, 5'd5, 5'd0, 32'h04, 1'b0, 1'b0,
               1'b0, 1'b1, C_LW,   2'b00, 1'b1, 5'd1, 5'd5, 6'h04};
    vt[1]  = '{1'b1, C_ADD, 2'b10, 1'b1, 1'b1, 5'd5, 5'd2, 5'd3, 32'h20, 1'b0, 1'b0,
               1'b1, 1'b0, C_NONE, 2'b00, 1'b0, 5'd0, 5'd0, 6'h00};
    vt[2]  = '{1'b1, C_ADD, 2'b10, 1'b1, 1'b1, 5'd5, 5'd2, 5'd3, 32'h20, 1'b0, 1'b0,
               1'b0, 1'b1, C_ADD,  2'b10, 1'b1, 5'd5, 5'd2, 6'h20};
    vt[3]  = '{1'b1, C_LW,  2'b00, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 32'h08, 1'b0, 1'b0,
               1'b0, 1'b1, C_LW,   2'b00, 1'b1, 5'd2, 5'd0, 6'h08};
    vt[4]  = '{1'b1, C_ADD, 2'b10, 1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 32'h24, 1'b0, 1'b0,
               1'b0, 1'b1, C_ADD,  2'b10, 1'b1, 5'd0, 5'd0, 6'h24};
    vt[5]  = '{1'b1, C_LW,  2'b00, 1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'h10, 1'b0, 1'b0,
               1'b0, 1'b1, C_LW,   2'b00, 1'b1, 5'd3, 5'd7, 6'h10};
    vt[6]  = '{1'b1, C_ADD, 2'b00, 1'b1, 1'b0, 5'd1, 5'd7, 5'd0, 32'h22, 1'b0, 1'b0,
               1'b0, 1'b1, C_ADD,  2'b00, 1'b1, 5'd1, 5'd7, 6'h22};
    vt[7]  = '{1'b1, C_LW,  2'b00, 1'b1, 1'b0, 5'd4, 5'd9, 5'd0, 32'h0c, 1'b0, 1'b0,
               1'b0, 1'b1, C_LW,   2'b00, 1'b1, 5'd4, 5'd9, 6'h0c};
    vt[8]  = '{1'b1, C_SW,  2'b00, 1'b1, 1'b1, 5'd6, 5'd9, 5'd0, 32'h14, 1'b0, 1'b1,
               1'b1, 1'b0, C_NONE, 2'b00, 1'b0, 5'd0, 5'd0, 6'h00};
    vt[9]  = '{1'b1, C_SW,  2'b00, 1'b1, 1'b1, 5'd6, 5'd9, 5'd0, 32'h14, 1'b0, 1'b0,
               1'b0, 1'b1, C_SW,   2'b00, 1'b1, 5'd6, 5'd9, 6'h14};
    vt[10] = '{1'b0, C_LW,  2'b00, 1'b1, 1'b0, 5'd9, 5'd1, 5'd0, 32'h30, 1'b0, 1'b0,
               1'b0, 1'b0, C_NONE, 2'b00, 1'b1, 5'd9, 5'd1, 6'h30};
    vt[11] = '{1'b1, C_ADD, 2'b10, 1'b1, 1'b1, 5'd2, 5'd3, 5'd1, 32'h25, 1'b1, 1'b1,
               1'b0, 1'b0, C_NONE, 2'b00, 1'b0, 5'd0, 5'd0, 6'h00};

    // ---------------- reset with busy ID inputs ----------------
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    drive(1'b1, 7'h7f, 2'b11, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'hffff_ffff);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.ex_valid), 64'd0);
    check("rst_ctrl", 64'(ex_ctrl()), 64'd0);
    check("rst_alu_op", 64'(bus.ex_alu_op), 64'd0);
    check("rst_funct", 64'(bus.ex_funct), 64'd0);
    check("rst_data", 64'(bus.ex_rs_data | bus.ex_rt_data | bus.ex_imm | bus.ex_pc4), 64'd0);
    check("rst_regs", 64'({bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt}), 64'd0);
    check("rst_hazard", 64'(hazard_stall), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, C_ADD, 2'b10, 1'b1, 1'b1, 5'd8, 5'd9, 5'd10, 32'd32);
    @(posedge clk); #1;
    check("rel_alu_op", 64'(bus.ex_alu_op), 64'(2'b10));
    check("rel_funct", 64'(bus.ex_funct), 64'd32);
    check("rel_valid", 64'(bus.ex_valid), 64'd1);

    // ---------------- vector table ----------------
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vt[i].valid, vt[i].ctrl, vt[i].op, vt[i].urs, vt[i].urt,
            vt[i].rs, vt[i].rt, vt[i].rd, vt[i].imm);
      hold  = vt[i].hold;
      flush = vt[i].flush;
      #1;
      check($sformatf("v%0d_hazard", i), 64'(hazard_stall), 64'(vt[i].e_hz));
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), 64'(bus.ex_valid), 64'(vt[i].e_valid));
      check($sformatf("v%0d_ctrl", i), 64'(ex_ctrl()), 64'(vt[i].e_ctrl));
      check($sformatf("v%0d_alu_op", i), 64'(bus.ex_alu_op), 64'(vt[i].e_op));
      if (vt[i].chk) begin
        check($sformatf("v%0d_rs", i), 64'(bus.ex_rs), 64'(vt[i].e_rs));
        check($sformatf("v%0d_rt", i), 64'(bus.ex_rt), 64'(vt[i].e_rt));
        check($sformatf("v%0d_funct", i), 64'(bus.ex_funct), 64'(vt[i].e_funct));
        check($sformatf("v%0d_rs_data", i), 64'(bus.ex_rs_data), 64'(32'h1000 + 32'(vt[i].e_rs)));
        check($sformatf("v%0d_rt_data", i), 64'(bus.ex_rt_data), 64'(32'h2000 + 32'(vt[i].e_rt)));
      end
    end

    // ---------------- hold for three edges ----------------
    @(negedge clk);
    hold = 1'b0; flush = 1'b0;
    drive(1'b1, C_ADD, 2'b11, 1'b1, 1'b1, 5'd8, 5'd10, 5'd11, 32'h24);
    @(posedge clk); #1;
    check("and_alu_op", 64'(bus.ex_alu_op), 64'(2'b11));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hold = 1'b1;
      drive(1'b1, C_SW, 2'(k), 1'b0, 1'b0, 5'(20 + k), 5'(k), 5'(k), 32'(k + 1));
      @(posedge clk); #1;
      check($sformatf("hold%0d_alu_op", k), 64'(bus.ex_alu_op), 64'(2'b11));
      check($sformatf("hold%0d_rs", k), 64'(bus.ex_rs), 64'd8);
      check($sformatf("hold%0d_funct", k), 64'(bus.ex_funct), 64'h24);
      check($sformatf("hold%0d_ctrl", k), 64'(ex_ctrl()), 64'(C_ADD));
    end
    @(negedge clk);
    hold = 1'b0;
    drive(1'b1, C_SW, 2'b01, 1'b1, 1'b1, 5'd23, 5'd4, 5'd0, 32'h2a);
    @(posedge clk); #1;
    check("unhold_rs", 64'(bus.ex_rs), 64'd23);
    check("unhold_alu_op", 64'(bus.ex_alu_op), 64'(2'b01));
    check("unhold_funct", 64'(bus.ex_funct), 64'h2a);
    check("unhold_ctrl", 64'(ex_ctrl()), 64'(C_SW));

    // ---------------- hold coincident with load-use ----------------
    @(negedge clk);
    drive(1'b1, C_LW, 2'b00, 1'b1, 1'b0, 5'd1, 5'd12, 5'd0, 32'h04);
    @(posedge clk); #1;
    check("sim_lw_in_ex", 64'(bus.ex_mem_read), 64'd1);
    @(negedge clk);
    hold = 1'b1;
    drive(1'b1, C_ADD, 2'b10, 1'b1, 1'b0, 5'd12, 5'd3, 5'd6, 32'h20);
    #1;
    check("sim_hz_pre", 64'(hazard_stall), 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("sim_hold_mem_read", 64'(bus.ex_mem_read), 64'd1);
      check("sim_hold_rt", 64'(bus.ex_rt), 64'd12);
      check("sim_hold_hz", 64'(hazard_stall), 64'd1);
    end
    @(negedge clk);
    hold = 1'b0;
    @(posedge clk); #1;
    check("sim_bubble_valid", 64'(bus.ex_valid), 64'd0);
    check("sim_bubble_mem_read", 64'(bus.ex_mem_read), 64'd0);
    check("sim_bubble_hz", 64'(hazard_stall), 64'd0);
    @(posedge clk); #1;
    check("sim_dep_valid", 64'(bus.ex_valid), 64'd1);
    check("sim_dep_rs", 64'(bus.ex_rs), 64'd12);
    check("sim_dep_ctrl", 64'(ex_ctrl()), 64'(C_ADD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline. It sits directly upstream of the ALU control unit and the ALU.
- Each cycle it captures decoded control and operands from ID and presents them to EX. It drives ALUOp and Funct into ALU control.
- Contains load-use hazard detection, bubble insertion, hold (stall) and flush (branch / jr) handling.

Parameters:
DATA_W, 32, width of register operands, sign-extended immediate and PC+4
REG_W, 5, register-address width

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
id_valid  in  1  ID stage holds a real instruction
id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  decoded control bits
id_alu_op  in  2  00 add, 01 sub, 10 R-format, 11 and
id_uses_rs, id_uses_rt  in  1 each  instruction reads rs / rt
id_rs_data, id_rt_data, id_imm, id_pc4  in  DATA_W each  operands, sign-extended immediate, PC+4
id_rs, id_rt, id_rd  in  REG_W each  register numbers
id_shamt  in  5  shift amount
hold  in  1  downstream stall: freeze register contents
flush  in  1  branch taken or jr resolved in EX: kill the instruction entering EX
hazard_stall  out  1  load-use detected; IF/ID and PC must hold
ex_valid  out  1  EX holds a real instruction
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst  out  1 each  registered control bits
ex_alu_op  out  2  to ALU control ALUOp
ex_funct  out  6  to ALU control Funct; equals ex_imm[5:0]
ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W each  registered operands
ex_rs, ex_rt, ex_rd  out  REG_W each  registered register numbers
ex_shamt  out  5  registered shift amount

Behaviour:
- Reset: on a clk edge with rst_n=0, every ex_* output goes to 0. ex_alu_op=00 and ex_funct=0, so a reset bubble decodes as add with no side effects. hazard_stall is 0 after reset because ex_valid=0.
- hazard_stall is combinational, with no latency. It is 1 when all of the following hold:
  - ex_valid & ex_mem_read & id_valid & ex_rt != 0
  - (id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)
- Register 0 never causes a hazard.
- Next-state priority, evaluated every rising edge:
  1. rst_n=0: clear everything.
  2. flush=1: load bubble. ex_valid and all seven control bits go to 0, ex_alu_op=00. Data fields may load ID values (don't-care).
  3. hold=1: all ex_* keep their values. hazard_stall still reflects the current comparison.
  4. hazard_stall=1: load bubble, same as the flush bubble.
  5. Otherwise: load all id_* fields, with ex_valid=id_valid.
- If id_valid=0 on a normal load, control bits are forced to 0 regardless of the id_* control inputs.
- Latency is 1 cycle from ID inputs to ex_* outputs. A load-use pair produces exactly one bubble:
  - cycle N: the load is in EX, hazard_stall=1 and a bubble loads.
  - cycle N+1: the load has moved on, ex_mem_read=0, hazard_stall=0 and the dependent instruction loads.
- Flush and hazard in the same cycle: flush wins, giving one bubble. hazard_stall output still asserts that cycle; upstream flush logic overrides it.
- Hold and hazard in the same cycle: hold wins, so EX keeps the load and hazard_stall stays asserted. The bubble is inserted on the first cycle hold drops.
- ex_funct is derived from the registered immediate, not stored separately.

Test Plan:
- Reset: drive id_* with nonzero values, rst_n=0 for 2 edges -> all ex_* = 0, hazard_stall=0. Release with id_alu_op=10, id_imm=32 -> next edge ex_alu_op=10, ex_funct=32, ex_valid=1.
- Load-use:
  - Stimulus: lw with rt=5 loaded into EX. ID has add with rs=5 and id_uses_rs=1.
  - Required response: hazard_stall=1 immediately; next edge ex_valid=0 and ex_mem_read=0. Following edge the add loads with ex_rs=5.
- Zero register: lw rt=0 in EX, ID rs=0 -> hazard_stall=0 and the ID instruction loads normally.
- Flush: ID has sw (id_mem_write=1), flush=1 for one edge -> ex_valid=0, ex_mem_write=0. Next edge with flush=0 loads the new ID instruction.
- Hold:
  - Stimulus: EX holds and with ex_alu_op=11; hold=1 for 3 edges while id_* changes every cycle.
  - Required response: ex_* unchanged for 3 edges. First edge after hold drops captures the current id_*.
- Simultaneous: load-use condition with hold=1 -> lw stays in EX and hazard_stall=1. hold drops -> bubble next edge, then the dependent instruction the edge after.
